// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester byte streams and UART TX byte channel bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_valid;
   logic [7:0]           tx_data;
   logic                 tx_ready;

   // master: requesters plus the UART transmitter; slave: the arbiter
   modport master (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_valid, tx_data
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_valid, tx_data
   );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Packet-locked round-robin arbiter sharing one UART TX byte channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int MAX_BURST = 64
) (
   input  logic                ifclk,
   input  logic                reset,
   input  logic                en,
   uart_tx_arbiter_if.slave    bus,
   output logic [NUM_REQ-1:0]  grant,
   output logic                busy,
   output logic                burst_abort
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t             state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [IDX_W-1:0]   gidx_q;
   logic [IDX_W-1:0]   last_ptr_q;
   logic               busy_q;
   logic               abort_q;
   logic [7:0]         byte_cnt_q;
   logic [7:0]         byte_cnt_d;

   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic [IDX_W-1:0]   scan_idx;
   logic               in_xfer;
   logic               xfer_fire;
   logic               cur_last;

   // Scan downward so the candidate closest after last_ptr is the one kept
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_idx  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         scan_idx = IDX_W'((int'(last_ptr_q) + k) % NUM_REQ);
         if (bus.req_valid[scan_idx]) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx;
         end
      end
   end

   assign in_xfer    = (state_q == ST_XFER);
   assign xfer_fire  = in_xfer & bus.req_valid[gidx_q] & bus.tx_ready;
   assign cur_last   = bus.req_last[gidx_q];
   assign byte_cnt_d = byte_cnt_q + 8'd1;

   assign bus.tx_valid  = in_xfer & bus.req_valid[gidx_q];
   assign bus.tx_data   = in_xfer ? bus.req_data[{gidx_q, 3'b000} +: 8] : 8'h00;
   assign bus.req_ready = grant_q & {NUM_REQ{bus.tx_ready}};

   assign grant       = grant_q;
   assign busy        = busy_q;
   assign burst_abort = abort_q;

   always_ff @(posedge ifclk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         busy_q     <= 1'b0;
         abort_q    <= 1'b0;
         byte_cnt_q <= '0;
         last_ptr_q <= IDX_W'(NUM_REQ - 1);
      end else begin
         abort_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (en && sel_found) begin
                  state_q    <= ST_XFER;
                  grant_q    <= NUM_REQ'(1) << sel_idx;
                  gidx_q     <= sel_idx;
                  busy_q     <= 1'b1;
                  byte_cnt_q <= '0;
               end
            end
            ST_XFER: begin
               if (xfer_fire) begin
                  byte_cnt_q <= byte_cnt_d;
                  // A watchdog release looks exactly like a packet end, plus the abort pulse
                  if (cur_last || (byte_cnt_d == 8'(MAX_BURST))) begin
                     state_q    <= ST_IDLE;
                     grant_q    <= '0;
                     busy_q     <= 1'b0;
                     last_ptr_q <= gidx_q;
                     abort_q    <= ~cur_last;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
